// File: rtl/branch_comp_seq.sv
// Multi-cycle RV32I branch comparator: CHUNK bits per cycle, MS chunk first, valid/ready on both sides.
// Optional macro BRCOMP_EARLY_EXIT_EN: stop scanning at the first differing chunk (otherwise fixed NCHUNK cycles).
module branch_comp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_out,
  input  logic [XLEN-1:0] rs2_out,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_taken
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
      $error("branch_comp_seq: XLEN must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic [XLEN-1:0]   a_r, b_r;
  logic [2:0]        f3_r;
  logic [IDXW-1:0]   idx_r;
  logic [XLEN-1:0]   sign_mask_s;
  logic [CHUNK-1:0]  a_top_s, b_top_s;
  logic              diff_s, chunk_lt_s, last_s, accept_s, finish_s;
  logic              res_eq_s, res_lt_s;
`ifndef BRCOMP_EARLY_EXIT_EN
  logic              dec_r, dec_lt_r;
`endif

  function automatic logic taken_f(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'b000:         t = eq;
      3'b001:         t = ~eq;
      3'b100, 3'b110: t = lt;
      3'b101, 3'b111: t = ~lt;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);
  assign accept_s  = in_valid && in_ready;

  // Flipping the sign bit of both operands maps signed order onto unsigned order.
  assign sign_mask_s = {~funct3[1], {(XLEN-1){1'b0}}};

  // Chunk comparison and the result that would be committed on leaving CMP.
  always_comb begin
    a_top_s    = a_r[XLEN-1 -: CHUNK];
    b_top_s    = b_r[XLEN-1 -: CHUNK];
    diff_s     = (a_top_s != b_top_s);
    chunk_lt_s = (a_top_s < b_top_s);
    last_s     = (idx_r == {IDXW{1'b0}});
`ifdef BRCOMP_EARLY_EXIT_EN
    finish_s   = diff_s || last_s;
    res_eq_s   = ~diff_s;
    res_lt_s   = chunk_lt_s;
`else
    // The most significant differing chunk wins; later chunks cannot overwrite it.
    finish_s   = last_s;
    res_eq_s   = ~dec_r && ~diff_s;
    res_lt_s   = dec_r ? dec_lt_r : chunk_lt_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = CMP;
        else          state_nx_s = IDLE;
      end
      CMP: begin
        if (finish_s) state_nx_s = DONE;
        else          state_nx_s = CMP;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register, operand shifter and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      f3_r     <= 3'b000;
      idx_r    <= {IDXW{1'b0}};
      br_eq    <= 1'b0;
      br_lt    <= 1'b0;
      br_taken <= 1'b0;
`ifndef BRCOMP_EARLY_EXIT_EN
      dec_r    <= 1'b0;
      dec_lt_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        a_r      <= rs1_out ^ sign_mask_s;
        b_r      <= rs2_out ^ sign_mask_s;
        f3_r     <= funct3;
        idx_r    <= IDXW'(NCHUNK - 1);
`ifndef BRCOMP_EARLY_EXIT_EN
        dec_r    <= 1'b0;
        dec_lt_r <= 1'b0;
`endif
      end else if (state_r == CMP) begin
        a_r   <= a_r << CHUNK;
        b_r   <= b_r << CHUNK;
        idx_r <= last_s ? idx_r : (idx_r - IDXW'(1));
`ifndef BRCOMP_EARLY_EXIT_EN
        if (!dec_r && diff_s) begin
          dec_r    <= 1'b1;
          dec_lt_r <= chunk_lt_s;
        end
`endif
        if (finish_s) begin
          br_eq    <= res_eq_s;
          br_lt    <= res_lt_s;
          br_taken <= taken_f(f3_r, res_eq_s, res_lt_s);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Directed self-checking bench for branch_comp_seq (XLEN=32, CHUNK=8).
module tb_branch_comp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_out, rs2_out;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic        br_eq, br_lt, br_taken;

  int total = 0;
  int bad   = 0;

`ifdef BRCOMP_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  branch_comp_seq #(.XLEN(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .br_eq(br_eq), .br_lt(br_lt), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

  // Accept one operation, scramble inputs, then measure latency and check results.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic eeq, input logic elt,
                        input logic etk, input int elat);
    int lat;
    lat = 0;
    `CHK({tag, "_in_ready"}, in_ready, 1'b1)
    in_valid = 1'b1; rs1_out = a; rs2_out = b; funct3 = f;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1_out = ~a; rs2_out = ~b; funct3 = ~f;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $error("FAIL %s_timeout: out_valid not seen within %0d cycles", tag, lat);
    end
    `CHK({tag, "_latency"}, lat, elat)
    `CHK({tag, "_out_valid"}, out_valid, 1'b1)
    `CHK({tag, "_br_eq"}, br_eq, eeq)
    `CHK({tag, "_br_lt"}, br_lt, elt)
    `CHK({tag, "_br_taken"}, br_taken, etk)
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    `CHK({tag, "_rel_out_valid"}, out_valid, 1'b0)
    `CHK({tag, "_rel_in_ready"}, in_ready, 1'b1)
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1_out = 32'h0; rs2_out = 32'h0; funct3 = 3'b000;
    @(posedge clk); #1;
    `CHK("reset_in_ready", in_ready, 1'b0)
    @(posedge clk); #1;
    total++;
    if ({out_valid, br_eq, br_lt, br_taken} !== 4'b0000) begin
      bad++;
      $error("FAIL reset_state: out_valid=%0b br_eq=%0b br_lt=%0b br_taken=%0b",
             out_valid, br_eq, br_lt, br_taken);
    end
    `CHK("reset_out_valid", out_valid, 1'b0)
    `CHK("reset_br_eq", br_eq, 1'b0)
    `CHK("reset_br_lt", br_lt, 1'b0)
    `CHK("reset_br_taken", br_taken, 1'b0)
    rst = 1'b0;
    #1;
    `CHK("post_reset_in_ready", in_ready, 1'b1)

    run_op("beq_equal", 32'h12345678, 32'h12345678, 3'b000, 1'b1, 1'b0, 1'b1, 4);
    release_result("beq_equal");

    run_op("blt_neg", 32'h80000000, 32'h00000001, 3'b100, 1'b0, 1'b1, 1'b1, EARLY ? 1 : 4);
    release_result("blt_neg");

    run_op("bltu_big", 32'h80000000, 32'h00000001, 3'b110, 1'b0, 1'b0, 1'b0, EARLY ? 1 : 4);
    release_result("bltu_big");

    run_op("bge_ff_100", 32'h000000FF, 32'h00000100, 3'b101, 1'b0, 1'b1, 1'b0, EARLY ? 3 : 4);
    release_result("bge_ff_100");

    run_op("bgeu_equal", 32'h00000005, 32'h00000005, 3'b111, 1'b1, 1'b0, 1'b1, 4);
    release_result("bgeu_equal");

    run_op("f3_010", 32'h00000001, 32'h00000002, 3'b010, 1'b0, 1'b1, 1'b0, 4);
    release_result("f3_010");

    // Backpressure: BLTU 1 < 0xFFFFFFFF held for 5 cycles while a new request is offered.
    run_op("bp", 32'h00000001, 32'hFFFFFFFF, 3'b110, 1'b0, 1'b1, 1'b1, EARLY ? 1 : 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2) ? 1'b1 : 1'b0;
      rs1_out = 32'h7; rs2_out = 32'h7; funct3 = 3'b000;
      @(posedge clk); #1;
      `CHK("bp_hold_out_valid", out_valid, 1'b1)
      `CHK("bp_hold_in_ready", in_ready, 1'b0)
      `CHK("bp_hold_br_eq", br_eq, 1'b0)
      `CHK("bp_hold_br_lt", br_lt, 1'b1)
      `CHK("bp_hold_br_taken", br_taken, 1'b1)
    end
    in_valid = 1'b0;
    release_result("bp");
    @(posedge clk); #1;
    `CHK("bp_ignored_out_valid", out_valid, 1'b0)
    `CHK("bp_idle_keeps_br_lt", br_lt, 1'b1)

    // Leave br_eq/br_taken high so the reset clear is observable.
    run_op("pre_rst", 32'h00000005, 32'h00000005, 3'b111, 1'b1, 1'b0, 1'b1, 4);
    release_result("pre_rst");

    // Abort a BEQ in CMP with a one-cycle reset.
    in_valid = 1'b1; rs1_out = 32'h12345678; rs2_out = 32'h12345678; funct3 = 3'b000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    `CHK("abort_in_ready_in_rst", in_ready, 1'b0)
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    `CHK("abort_in_ready", in_ready, 1'b1)
    `CHK("abort_out_valid", out_valid, 1'b0)
    `CHK("abort_br_eq", br_eq, 1'b0)
    `CHK("abort_br_lt", br_lt, 1'b0)
    `CHK("abort_br_taken", br_taken, 1'b0)
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        seen = seen | out_valid;
      end
      `CHK("abort_no_out_valid", seen, 1'b0)
    end

    run_op("bne_1_2", 32'h00000001, 32'h00000002, 3'b001, 1'b0, 1'b1, 1'b1, 4);
    release_result("bne_1_2");

    if (bad != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", bad, total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
